frequency_analyzer_scheduler: RTL and testbench

FREQUENCY_ANALYZER_SCHEDULER -- requirements
Module: frequency_analyzer_scheduler

---
 rtl/frequency_analyzer_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_frequency_analyzer_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frequency_analyzer_scheduler.sv
// Ping-pong scheduler for two frequency analyzers: alternates fixed-length measurement windows,
// collects their results with a guard timeout and streams them out over a valid/ready port.
module frequency_analyzer_scheduler #(
    parameter int unsigned CLOCK        = 100000000,
    parameter int unsigned FREQUENCY    = 2000,
    parameter int unsigned GUARD_TICKS  = 20,
    parameter int unsigned RESULT_WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    clear_status,
    output logic                    start_0,
    output logic                    stop_0,
    output logic                    start_1,
    output logic                    stop_1,
    input  logic                    done_0,
    input  logic                    done_1,
    input  logic [RESULT_WIDTH-1:0] result_0,
    input  logic [RESULT_WIDTH-1:0] result_1,
    output logic [RESULT_WIDTH-1:0] out_data,
    output logic                    out_channel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    overrun,
    output logic                    timeout
);
    localparam int unsigned W  = CLOCK / FREQUENCY;
    localparam int unsigned CW = $clog2(W);
    localparam int unsigned GW = $clog2(GUARD_TICKS + 1);
    localparam logic [CW-1:0] LAST      = CW'(W - 1);
    localparam logic [GW-1:0] GUARD_MAX = GW'(GUARD_TICKS);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e                       state_q, state_d;
    logic [CW-1:0]                count_q, count_d;
    logic                         active_q, active_d;
    logic [1:0]                   start_q, start_d;
    logic [1:0]                   stop_q, stop_d;
    logic [1:0]                   wait_q, wait_d;
    logic [1:0][GW-1:0]           guard_q, guard_d;
    logic [1:0][RESULT_WIDTH-1:0] slot_q, slot_d;
    logic [1:0]                   slot_valid_q, slot_valid_d;
    logic                         ptr_q, ptr_d;
    logic [RESULT_WIDTH-1:0]      out_data_q, out_data_d;
    logic                         out_channel_q, out_channel_d;
    logic                         out_valid_q, out_valid_d;
    logic                         overrun_q, overrun_d;
    logic                         timeout_q, timeout_d;

    logic [1:0]                   done;
    logic [1:0][RESULT_WIDTH-1:0] result;
    logic [1:0]                   capture;
    logic                         timeout_set;
    logic                         overrun_set;
    logic                         sel;

    assign done   = {done_1, done_0};
    assign result = {result_1, result_0};

    // Window sequencing: a window always runs to its end, enable only decides what follows it.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        active_d = active_q;
        start_d  = '0;
        stop_d   = '0;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d    = StRun;
                    count_d    = '0;
                    active_d   = 1'b0;
                    start_d[0] = 1'b1;
                end
            end
            StRun: begin
                if (count_q == LAST) begin
                    count_d          = '0;
                    stop_d[active_q] = 1'b1;
                    if (enable) begin
                        active_d          = ~active_q;
                        start_d[~active_q] = 1'b1;
                    end else begin
                        state_d = StDrain;
                    end
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            StDrain: begin
                if (wait_q == '0) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Per-channel result wait with guard timeout.
    always_comb begin
        wait_d      = wait_q;
        guard_d     = guard_q;
        capture     = '0;
        timeout_set = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (wait_q[i]) begin
                if (done[i]) begin
                    wait_d[i]  = 1'b0;
                    capture[i] = 1'b1;
                end else if (guard_q[i] == GUARD_MAX) begin
                    wait_d[i]   = 1'b0;
                    timeout_set = 1'b1;
                end else begin
                    guard_d[i] = guard_q[i] + 1'b1;
                end
            end
            if (stop_d[i]) begin
                wait_d[i]  = 1'b1;
                guard_d[i] = '0;
            end
        end
    end

    // Output register refills from the slots round-robin; a slot freed this cycle may be refilled.
    always_comb begin
        out_data_d    = out_data_q;
        out_channel_d = out_channel_q;
        out_valid_d   = out_valid_q;
        ptr_d         = ptr_q;
        slot_d        = slot_q;
        slot_valid_d  = slot_valid_q;
        overrun_set   = 1'b0;
        sel           = slot_valid_q[ptr_q] ? ptr_q : ~ptr_q;
        if (!out_valid_q || out_ready) begin
            out_valid_d = 1'b0;
            if (slot_valid_q != '0) begin
                out_valid_d       = 1'b1;
                out_data_d        = slot_q[sel];
                out_channel_d     = sel;
                slot_valid_d[sel] = 1'b0;
                ptr_d             = ~sel;
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (capture[i]) begin
                if (slot_valid_d[i]) begin
                    overrun_set = 1'b1;
                end else begin
                    slot_d[i]       = result[i];
                    slot_valid_d[i] = 1'b1;
                end
            end
        end
    end

    assign overrun_d = (overrun_q & ~clear_status) | overrun_set;
    assign timeout_d = (timeout_q & ~clear_status) | timeout_set;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            count_q       <= '0;
            active_q      <= 1'b0;
            start_q       <= '0;
            stop_q        <= '0;
            wait_q        <= '0;
            guard_q       <= '0;
            slot_q        <= '0;
            slot_valid_q  <= '0;
            ptr_q         <= 1'b0;
            out_data_q    <= '0;
            out_channel_q <= 1'b0;
            out_valid_q   <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            active_q      <= active_d;
            start_q       <= start_d;
            stop_q        <= stop_d;
            wait_q        <= wait_d;
            guard_q       <= guard_d;
            slot_q        <= slot_d;
            slot_valid_q  <= slot_valid_d;
            ptr_q         <= ptr_d;
            out_data_q    <= out_data_d;
            out_channel_q <= out_channel_d;
            out_valid_q   <= out_valid_d;
            overrun_q     <= overrun_d;
            timeout_q     <= timeout_d;
        end
    end

    assign start_0     = start_q[0];
    assign start_1     = start_q[1];
    assign stop_0      = stop_q[0];
    assign stop_1      = stop_q[1];
    assign out_data    = out_data_q;
    assign out_channel = out_channel_q;
    assign out_valid   = out_valid_q;
    assign busy        = (state_q != StIdle);
    assign overrun     = overrun_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_frequency_analyzer_scheduler.sv
// Bench for frequency_analyzer_scheduler: cycle-indexed behavioural model checked every cycle,
// plus directed literal expectations at hand-computed cycles.
module tb_frequency_analyzer_scheduler;
    localparam int W     = 10;
    localparam int GUARD = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        clear_status = 1'b0;
    logic        start_0, stop_0, start_1, stop_1;
    logic        done_0 = 1'b0;
    logic        done_1 = 1'b0;
    logic [15:0] result_0 = '0;
    logic [15:0] result_1 = '0;
    logic [15:0] out_data;
    logic        out_channel, out_valid;
    logic        out_ready = 1'b0;
    logic        busy, overrun, timeout;

    frequency_analyzer_scheduler #(
        .CLOCK(100), .FREQUENCY(10), .GUARD_TICKS(3), .RESULT_WIDTH(16)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .clear_status(clear_status),
        .start_0(start_0), .stop_0(stop_0), .start_1(start_1), .stop_1(stop_1),
        .done_0(done_0), .done_1(done_1), .result_0(result_0), .result_1(result_1),
        .out_data(out_data), .out_channel(out_channel), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .overrun(overrun), .timeout(timeout)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Model: the cycle index of the current outputs, window timing by arithmetic on cycle numbers,
    // result waits by absolute deadlines.
    int          cyc = 0;
    bit          m_ok = 0;
    int          mode = 0;  // 0 idle, 1 running windows, 2 draining
    int          wstart = 0;
    int          ch = 0;
    bit [1:0]    e_start = 0, e_stop = 0, pend = 0, full = 0;
    int          dl [2];
    logic [15:0] sval [2];
    int          ptr = 0;
    bit          e_ov = 0, e_oc = 0, e_ovr = 0, e_to = 0;
    logic [15:0] e_od = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        int cur, nxt, s;
        bit drain_clear, set_to, set_ovr;
        logic [1:0] dn;
        logic [15:0] rs [2];
        dn = {done_1, done_0};
        rs[0] = result_0;
        rs[1] = result_1;
        if (reset) begin
            mode = 0; ch = 0; e_start = 0; e_stop = 0; pend = 0; full = 0; ptr = 0;
            e_ov = 0; e_od = '0; e_oc = 0; e_ovr = 0; e_to = 0; cyc = 0; m_ok = 1;
            return;
        end
        cur = cyc;
        nxt = cyc + 1;
        drain_clear = (pend == 2'b00);
        if (!e_ov || out_ready) begin
            e_ov = 0;
            if (full[ptr]) s = ptr;
            else if (full[1-ptr]) s = 1 - ptr;
            else s = -1;
            if (s >= 0) begin
                e_ov = 1; e_od = sval[s]; e_oc = s[0]; full[s] = 0; ptr = 1 - s;
            end
        end
        set_to = 0;
        set_ovr = 0;
        for (int x = 0; x < 2; x++) begin
            if (pend[x]) begin
                if (dn[x]) begin
                    pend[x] = 0;
                    if (full[x]) set_ovr = 1;
                    else begin full[x] = 1; sval[x] = rs[x]; end
                end else if (cur == dl[x]) begin
                    pend[x] = 0;
                    set_to = 1;
                end
            end
        end
        e_start = 0;
        e_stop = 0;
        case (mode)
            0: if (enable) begin mode = 1; wstart = nxt; ch = 0; e_start[0] = 1; end
            1: if (nxt - wstart == W) begin
                e_stop[ch] = 1; pend[ch] = 1; dl[ch] = nxt + GUARD;
                if (enable) begin ch = 1 - ch; wstart = nxt; e_start[ch] = 1; end
                else mode = 2;
            end
            default: if (drain_clear) mode = 0;
        endcase
        e_ovr = (e_ovr && !clear_status) || set_ovr;
        e_to  = (e_to && !clear_status) || set_to;
        cyc = nxt;
    endtask

    always @(posedge clock) begin
        model_step();
        #1;
        if (m_ok) begin
            check("start_0", start_0, e_start[0]);
            check("start_1", start_1, e_start[1]);
            check("stop_0", stop_0, e_stop[0]);
            check("stop_1", stop_1, e_stop[1]);
            check("busy", busy, mode != 0);
            check("out_valid", out_valid, e_ov);
            check("overrun", overrun, e_ovr);
            check("timeout", timeout, e_to);
            if (e_ov) begin
                check("out_data", out_data, e_od);
                check("out_channel", out_channel, e_oc);
            end
        end
    end

    task automatic goto(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    task automatic pulse(input int c, input logic [15:0] v);
        if (c == 0) begin done_0 = 1'b1; result_0 = v; end
        else begin done_1 = 1'b1; result_1 = v; end
        @(negedge clock);
        done_0 = 1'b0;
        done_1 = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int npulse;
        repeat (3) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        reset = 1'b0;
        enable = 1'b1;
        out_ready = 1'b1;
        goto(1);
        check("lit_start_0_at_1", start_0, 1);
        check("lit_busy_at_1", busy, 1);
        goto(11);
        check("lit_stop_0_at_11", stop_0, 1);
        check("lit_start_1_at_11", start_1, 1);
        goto(13);
        pulse(0, 16'h1234);
        goto(15);
        check("lit_out_valid_at_15", out_valid, 1);
        check("lit_out_data_at_15", out_data, 16'h1234);
        check("lit_out_channel_at_15", out_channel, 0);
        goto(16);
        check("lit_out_valid_at_16", out_valid, 0);
        goto(21);
        check("lit_stop_1_at_21", stop_1, 1);
        check("lit_start_0_at_21", start_0, 1);
        goto(24);
        check("lit_timeout_at_24", timeout, 0);
        goto(25);
        check("lit_timeout_at_25", timeout, 1);
        goto(26);
        pulse(1, 16'hBEEF);
        goto(28);
        check("lit_late_done_ignored", out_valid, 0);
        clear_status = 1'b1;
        @(negedge clock);
        clear_status = 1'b0;
        check("lit_timeout_cleared", timeout, 0);
        goto(30);
        out_ready = 1'b0;
        goto(33);
        pulse(0, 16'hA001);
        goto(43);
        pulse(1, 16'hB001);
        goto(53);
        pulse(0, 16'hA002);
        goto(63);
        check("lit_overrun_at_63", overrun, 0);
        pulse(1, 16'hB002);
        check("lit_overrun_at_64", overrun, 1);
        check("lit_held_data_at_64", out_data, 16'hA001);
        check("lit_held_chan_at_64", out_channel, 0);
        goto(66);
        out_ready = 1'b1;
        goto(67);
        check("lit_release2_data", out_data, 16'hB001);
        check("lit_release2_chan", out_channel, 1);
        goto(68);
        check("lit_release3_data", out_data, 16'hA002);
        check("lit_release3_chan", out_channel, 0);
        goto(69);
        check("lit_release_done", out_valid, 0);
        goto(70);
        clear_status = 1'b1;
        @(negedge clock);
        clear_status = 1'b0;
        check("lit_overrun_cleared", overrun, 0);
        goto(85);
        enable = 1'b0;
        goto(91);
        check("lit_final_stop_0", stop_0, 1);
        check("lit_no_start_1", start_1, 0);
        goto(93);
        pulse(0, 16'h00C0);
        check("lit_drain_busy_at_94", busy, 1);
        goto(95);
        check("lit_idle_busy_at_95", busy, 0);
        check("lit_drain_result", out_data, 16'h00C0);
        goto(100);
        enable = 1'b1;
        goto(101);
        check("lit_restart_start_0", start_0, 1);
        goto(106);
        reset = 1'b1;
        @(negedge clock);
        check("lit_rst_stops", {stop_0, stop_1, start_0, start_1}, 0);
        check("lit_rst_busy", busy, 0);
        check("lit_rst_out", {out_valid, out_channel, out_data}, 0);
        check("lit_rst_flags", {overrun, timeout}, 0);
        @(negedge clock);
        reset = 1'b0;
        enable = 1'b0;
        npulse = 0;
        repeat (15) begin
            @(negedge clock);
            npulse += int'(start_0) + int'(stop_0) + int'(start_1) + int'(stop_1);
        end
        check("lit_no_pulse_after_reset", npulse, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
